ram_ctrl: RTL

//  Parametrised single-port data RAM with load/store handshake, programmable wait states,

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_ctrl_if.sv | 26 ++
 rtl/ram_array.sv | 31 +++
 rtl/ram_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the memory-side blocks: controller state encoding
// and wait-state counter width.
package ram_pkg;

    localparam int WAIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR  = 2'd0;
    localparam state_t ST_IDLE   = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_ACCESS = 2'd3;

endpackage

// File: rtl/ram_ctrl_if.sv
// Load/store handshake between the CPU memory stage (master) and the RAM
// controller (slave).
interface ram_ctrl_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write;
    logic              str;
    logic              ld;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] read;
    logic              err;
    logic              init_done;

    modport master (
        output addr, write, str, ld,
        input  ready, rvalid, read, err, init_done
    );

    modport slave (
        input  addr, write, str, ld,
        output ready, rvalid, read, err, init_done
    );
endinterface

// File: rtl/ram_array.sv
// DATA_W x DEPTH storage with one synchronous write port and one registered
// read port. Contents are not reset; the controller clears them after reset.
module ram_array #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Single-port data RAM controller: post-reset clear, load/store handshake,
// programmable wait states and registered read data with range checking.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W      = 20,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_ctrl_if.slave bus
);

    localparam int                 PTR_W     = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]    DEPTH_A   = (ADDR_W + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [WAIT_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              str_q, ld_q;
    logic [DATA_W-1:0] read_q;
    logic              rvalid_q, err_q, init_done_q;

    logic              ready;
    logic              accept;
    logic              in_range;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    assign accept   = ready & (bus.str | bus.ld);
    assign in_range = ({1'b0, addr_q} < DEPTH_A);
    assign mem_re   = ({1'b0, mem_raddr} < DEPTH_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:  if (ptr_q == PTR_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (bus.str | bus.ld) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (wcnt_q == '0) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // The array read is registered, so the address is presented one edge ahead:
    // straight from the bus while idle, from the capture register afterwards.
    always_comb begin
        ready     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        mem_raddr = addr_q;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(ptr_q);
                mem_wdata = '0;
            end
            ST_IDLE: begin
                ready     = 1'b1;
                mem_raddr = bus.addr;
            end
            ST_ACCESS: begin
                mem_we = str_q & in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            str_q       <= 1'b0;
            ld_q        <= 1'b0;
            read_q      <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR && ptr_q != PTR_LAST) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (state_q == ST_CLEAR && ptr_q == PTR_LAST) begin
                init_done_q <= 1'b1;
            end

            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.write;
                str_q   <= bus.str;
                ld_q    <= bus.ld;
                wcnt_q  <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && wcnt_q != '0) begin
                wcnt_q <= wcnt_q - 1'b1;
            end

            rvalid_q <= (state_q == ST_ACCESS) & ld_q;
            err_q    <= (state_q == ST_ACCESS) & ~in_range;

            // Combined store+load returns the freshly stored word.
            if (state_q == ST_ACCESS && ld_q) begin
                if (!in_range) begin
                    read_q <= '0;
                end else if (str_q) begin
                    read_q <= wdata_q;
                end else begin
                    read_q <= mem_rdata;
                end
            end
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign bus.ready     = ready;
    assign bus.rvalid    = rvalid_q;
    assign bus.read      = read_q;
    assign bus.err       = err_q;
    assign bus.init_done = init_done_q;

endmodule
